// File: rtl/osd_pkg.sv
// Shared definitions for the OSD reliability-sort and Gaussian-elimination stages:
// FSM state encoding, index-width derivation and the compare-exchange ordering rule.
package osd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SORT = 3'd2,
        ST_PERM = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int CS_W = 32;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // True when element b must move ahead of element a: larger magnitude wins,
    // equal magnitudes keep the lower original position first.
    function automatic logic cs_swap(input logic [CS_W-1:0] mag_a,
                                     input logic [CS_W-1:0] idx_a,
                                     input logic [CS_W-1:0] mag_b,
                                     input logic [CS_W-1:0] idx_b);
        return (mag_b > mag_a) || ((mag_b == mag_a) && (idx_b < idx_a));
    endfunction

endpackage

// File: rtl/osd_reliability_sort_if.sv
// Request/result bundle of the reliability sort: word inputs from the requester,
// permuted matrix, permutation and hard decisions back to it.
interface osd_reliability_sort_if
    import osd_pkg::*;
#(
    parameter int N     = 8,
    parameter int K     = 4,
    parameter int W     = 6,
    parameter int IDX_W = idx_width(N)
);
    logic                 start;
    logic [N*W-1:0]       llr_flat;
    logic [K*N-1:0]       G_flat;
    logic                 busy;
    logic                 done;
    logic [K*N-1:0]       Gpp_flat;
    logic [N*IDX_W-1:0]   perm_flat;
    logic [N-1:0]         hard_flat;

    modport master (
        output start, llr_flat, G_flat,
        input  busy, done, Gpp_flat, perm_flat, hard_flat
    );

    modport slave (
        input  start, llr_flat, G_flat,
        output busy, done, Gpp_flat, perm_flat, hard_flat
    );
endinterface

// File: rtl/osd_cmp_swap.sv
// Combinational compare-exchange of one {mag, idx} pair; the "a" outputs carry
// the element that belongs earlier in the reliability order.
module osd_cmp_swap
    import osd_pkg::*;
#(
    parameter int W     = 6,
    parameter int IDX_W = 3
) (
    input  logic [W-1:0]     i_mag_a,
    input  logic [IDX_W-1:0] i_idx_a,
    input  logic [W-1:0]     i_mag_b,
    input  logic [IDX_W-1:0] i_idx_b,
    output logic [W-1:0]     o_mag_a,
    output logic [IDX_W-1:0] o_idx_a,
    output logic [W-1:0]     o_mag_b,
    output logic [IDX_W-1:0] o_idx_b
);
    logic w_swap;

    assign w_swap  = cs_swap(CS_W'(i_mag_a), CS_W'(i_idx_a), CS_W'(i_mag_b), CS_W'(i_idx_b));
    assign o_mag_a = w_swap ? i_mag_b : i_mag_a;
    assign o_idx_a = w_swap ? i_idx_b : i_idx_a;
    assign o_mag_b = w_swap ? i_mag_a : i_mag_b;
    assign o_idx_b = w_swap ? i_idx_a : i_idx_b;
endmodule

// File: rtl/osd_reliability_sort.sv
// Orders codeword positions by decreasing |LLR| with an N-phase odd-even transposition
// sort, then column-permutes G and gathers hard decisions for the elimination stage.
module osd_reliability_sort
    import osd_pkg::*;
#(
    parameter int N     = 8,
    parameter int K     = 4,
    parameter int W     = 6,
    parameter int IDX_W = idx_width(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    osd_reliability_sort_if.slave  io_bus
);
    localparam int PH_W = idx_width(N);
    localparam int NE   = N / 2;
    localparam int NO   = (N - 1) / 2;

    state_t               r_state;
    logic [W-1:0]         r_mag [N];
    logic [IDX_W-1:0]     r_idx [N];
    logic [N-1:0]         r_sign;
    logic [K*N-1:0]       r_g;
    logic [PH_W-1:0]      r_phase;
    logic                 r_busy;
    logic                 r_done;
    logic [K*N-1:0]       r_gpp;
    logic [N*IDX_W-1:0]   r_perm;
    logic [N-1:0]         r_hard;

    logic [W-1:0]         w_load_mag [N];
    logic [W-1:0]         w_even_mag [N];
    logic [IDX_W-1:0]     w_even_idx [N];
    logic [W-1:0]         w_odd_mag  [N];
    logic [IDX_W-1:0]     w_odd_idx  [N];
    logic [K*N-1:0]       w_gpp;
    logic [N*IDX_W-1:0]   w_perm;
    logic [N-1:0]         w_hard;

    genvar gi, gj;

    // Two's-complement magnitude kept at W bits, so the most negative code maps to 2^(W-1).
    generate
        for (gi = 0; gi < N; gi++) begin : g_abs
            logic [W-1:0] w_llr;
            assign w_llr          = io_bus.llr_flat[gi*W +: W];
            assign w_load_mag[gi] = w_llr[W-1] ? ((~w_llr) + W'(1)) : w_llr;
        end
    endgenerate

    generate
        for (gi = 0; gi < NE; gi++) begin : g_even
            osd_cmp_swap #(.W(W), .IDX_W(IDX_W)) u_cs (
                .i_mag_a (r_mag[2*gi]),
                .i_idx_a (r_idx[2*gi]),
                .i_mag_b (r_mag[2*gi+1]),
                .i_idx_b (r_idx[2*gi+1]),
                .o_mag_a (w_even_mag[2*gi]),
                .o_idx_a (w_even_idx[2*gi]),
                .o_mag_b (w_even_mag[2*gi+1]),
                .o_idx_b (w_even_idx[2*gi+1])
            );
        end
        if (N % 2 == 1) begin : g_even_tail
            assign w_even_mag[N-1] = r_mag[N-1];
            assign w_even_idx[N-1] = r_idx[N-1];
        end

        for (gi = 0; gi < NO; gi++) begin : g_odd
            osd_cmp_swap #(.W(W), .IDX_W(IDX_W)) u_cs (
                .i_mag_a (r_mag[2*gi+1]),
                .i_idx_a (r_idx[2*gi+1]),
                .i_mag_b (r_mag[2*gi+2]),
                .i_idx_b (r_idx[2*gi+2]),
                .o_mag_a (w_odd_mag[2*gi+1]),
                .o_idx_a (w_odd_idx[2*gi+1]),
                .o_mag_b (w_odd_mag[2*gi+2]),
                .o_idx_b (w_odd_idx[2*gi+2])
            );
        end
        assign w_odd_mag[0] = r_mag[0];
        assign w_odd_idx[0] = r_idx[0];
        if (N % 2 == 0) begin : g_odd_tail
            assign w_odd_mag[N-1] = r_mag[N-1];
            assign w_odd_idx[N-1] = r_idx[N-1];
        end
    endgenerate

    // Gather stage: sorted index list selects G columns and sign bits.
    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            assign w_perm[gi*IDX_W +: IDX_W] = r_idx[gi];
            assign w_hard[gi]                = r_sign[r_idx[gi]];
        end
        for (gj = 0; gj < K; gj++) begin : g_row
            logic [N-1:0] w_row;
            assign w_row = r_g[gj*N +: N];
            for (gi = 0; gi < N; gi++) begin : g_bit
                assign w_gpp[gj*N + gi] = w_row[r_idx[gi]];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sign  <= '0;
            r_g     <= '0;
            r_phase <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gpp   <= '0;
            r_perm  <= '0;
            r_hard  <= '0;
            for (int j = 0; j < N; j++) begin
                r_mag[j] <= '0;
                r_idx[j] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (io_bus.start) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_g     <= io_bus.G_flat;
                    r_phase <= '0;
                    r_done  <= 1'b0;
                    for (int j = 0; j < N; j++) begin
                        r_sign[j] <= io_bus.llr_flat[j*W + W - 1];
                        r_mag[j]  <= w_load_mag[j];
                        r_idx[j]  <= IDX_W'(j);
                    end
                    r_state <= ST_SORT;
                end
                ST_SORT: begin
                    for (int j = 0; j < N; j++) begin
                        r_mag[j] <= r_phase[0] ? w_odd_mag[j] : w_even_mag[j];
                        r_idx[j] <= r_phase[0] ? w_odd_idx[j] : w_even_idx[j];
                    end
                    if (r_phase == PH_W'(N - 1)) begin
                        r_state <= ST_PERM;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                ST_PERM: begin
                    r_perm  <= w_perm;
                    r_gpp   <= w_gpp;
                    r_hard  <= w_hard;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.Gpp_flat  = r_gpp;
    assign io_bus.perm_flat = r_perm;
    assign io_bus.hard_flat = r_hard;
endmodule

// File: tb/tb_osd_reliability_sort.sv
// Directed plus randomized bench for osd_reliability_sort against a selection-sort
// reference model computed from |LLR| ordering with lower-index tie break.
module tb_osd_reliability_sort;
    localparam int N     = 8;
    localparam int K     = 4;
    localparam int W     = 6;
    localparam int IDX_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    osd_reliability_sort_if #(.N(N), .K(K), .W(W), .IDX_W(IDX_W)) bus ();

    osd_reliability_sort #(.N(N), .K(K), .W(W), .IDX_W(IDX_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    function automatic void model(input  logic [N*W-1:0]     llr,
                                  input  logic [K*N-1:0]     g,
                                  output logic [N*IDX_W-1:0] p_flat,
                                  output logic [N-1:0]       h,
                                  output logic [K*N-1:0]     gp);
        int  mag [N];
        bit  used [N];
        int  p [N];
        int  best;
        int  v;
        for (int j = 0; j < N; j++) begin
            v      = $signed(llr[j*W +: W]);
            mag[j] = (v < 0) ? -v : v;
            used[j] = 1'b0;
        end
        for (int r = 0; r < N; r++) begin
            best = -1;
            for (int j = 0; j < N; j++)
                if (!used[j] && (best < 0 || mag[j] > mag[best])) best = j;
            used[best] = 1'b1;
            p[r] = best;
        end
        p_flat = '0;
        h      = '0;
        gp     = '0;
        for (int r = 0; r < N; r++) begin
            p_flat[r*IDX_W +: IDX_W] = IDX_W'(p[r]);
            h[r] = llr[p[r]*W + W - 1];
            for (int i = 0; i < K; i++) gp[i*N + r] = g[i*N + p[r]];
        end
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
    endtask

    // Counts edges after the start sample until done is up with busy low.
    task automatic wait_done(input string tag, input int base);
        int cyc;
        cyc = base;
        while (!(bus.done === 1'b1 && bus.busy === 1'b0) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd10);
    endtask

    task automatic check_outputs(input string tag, input logic [N*W-1:0] llr, input logic [K*N-1:0] g);
        logic [N*IDX_W-1:0] ep;
        logic [N-1:0]       eh;
        logic [K*N-1:0]     eg;
        model(llr, g, ep, eh, eg);
        chk({tag, "_perm"}, 64'(bus.perm_flat), 64'(ep));
        chk({tag, "_hard"}, 64'(bus.hard_flat), 64'(eh));
        chk({tag, "_gpp"},  64'(bus.Gpp_flat),  64'(eg));
    endtask

    task automatic run_check(input string tag, input logic [N*W-1:0] llr, input logic [K*N-1:0] g);
        bus.llr_flat = llr;
        bus.G_flat   = g;
        pulse_start();
        wait_done(tag, 0);
        check_outputs(tag, llr, g);
        $display("run %s llr=%h G=%h perm=%h hard=%h Gpp=%h", tag, llr, g,
                 bus.perm_flat, bus.hard_flat, bus.Gpp_flat);
    endtask

    logic [N*W-1:0]     llr_v;
    logic [N*W-1:0]     llr_old;
    logic [K*N-1:0]     g_v;
    logic [K*N-1:0]     g_old;
    logic [N*IDX_W-1:0] exp_perm;
    logic [N*IDX_W-1:0] old_perm;
    logic [N-1:0]       old_hard;
    logic [K*N-1:0]     old_gpp;
    int                 vals [N];
    int                 ord [N];
    int                 v;
    int                 bad;

    initial begin
        bus.start    = 1'b0;
        bus.llr_flat = '0;
        bus.G_flat   = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;

        // Reset state
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_gpp",  64'(bus.Gpp_flat), 64'd0);
        chk("rst_perm", 64'(bus.perm_flat), 64'd0);
        chk("rst_hard", 64'(bus.hard_flat), 64'd0);

        // Scenario 1: hand-worked example
        vals = '{1, -7, 3, -2, 5, 0, -4, 6};
        ord  = '{1, 7, 4, 6, 2, 3, 0, 5};
        for (int j = 0; j < N; j++) begin
            v = vals[j];
            llr_v[j*W +: W] = v[W-1:0];
            exp_perm[j*IDX_W +: IDX_W] = IDX_W'(ord[j]);
        end
        g_v = {8'h08, 8'h04, 8'h02, 8'h01};
        run_check("ex1", llr_v, g_v);
        chk("ex1_perm_const", 64'(bus.perm_flat), 64'(exp_perm));
        chk("ex1_hard_const", 64'(bus.hard_flat), 64'(8'b00101001));
        chk("ex1_gpp_const",  64'(bus.Gpp_flat),  64'({8'h20, 8'h10, 8'h01, 8'h40}));

        // Scenario 2: all ties keep the original order
        for (int j = 0; j < N; j++) begin
            llr_v[j*W +: W] = W'(3);
            exp_perm[j*IDX_W +: IDX_W] = IDX_W'(j);
        end
        g_v = 32'hA5C3_1E96;
        run_check("ties", llr_v, g_v);
        chk("ties_perm_id", 64'(bus.perm_flat), 64'(exp_perm));
        chk("ties_gpp_eq_g", 64'(bus.Gpp_flat), 64'(g_v));

        // Scenario 3: most negative code outranks +31
        for (int j = 0; j < N; j++) llr_v[j*W +: W] = W'(31);
        llr_v[5*W +: W] = 6'b100000;
        ord = '{5, 0, 1, 2, 3, 4, 6, 7};
        for (int j = 0; j < N; j++) exp_perm[j*IDX_W +: IDX_W] = IDX_W'(ord[j]);
        run_check("minneg", llr_v, g_v);
        chk("minneg_perm_const", 64'(bus.perm_flat), 64'(exp_perm));
        chk("minneg_hard_const", 64'(bus.hard_flat), 64'(8'b00000001));

        // Scenario 4: reset during SORT phase 3
        llr_v = 48'h1234_5678_9ABC;
        bus.llr_flat = llr_v;
        pulse_start();
        repeat (4) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_gpp",  64'(bus.Gpp_flat), 64'd0);
        chk("midrst_perm", 64'(bus.perm_flat), 64'd0);
        chk("midrst_hard", 64'(bus.hard_flat), 64'd0);
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        chk("midrst_stays_idle", 64'(bad), 64'd0);
        run_check("after_rst", llr_v, 32'h0F0F_3C3C);

        // Scenario 5: start while busy is ignored and not queued
        llr_v = 48'hFEDC_BA98_7654;
        g_v   = 32'h1357_9BDF;
        bus.llr_flat = llr_v;
        bus.G_flat   = g_v;
        pulse_start();
        @(posedge clk); @(posedge clk); #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        wait_done("busy_start", 3);
        check_outputs("busy_start", llr_v, g_v);
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b1) bad++;
        end
        chk("busy_start_single", 64'(bad), 64'd0);
        llr_old = llr_v;
        g_old   = g_v;

        // Scenario 6: restart from DONE, old outputs held until the PERM edge
        model(llr_old, g_old, old_perm, old_hard, old_gpp);
        for (int j = 0; j < N; j++) begin
            v = vals[j];
            llr_v[j*W +: W] = v[W-1:0];
        end
        g_v = 32'h8421_C639;
        bus.llr_flat = llr_v;
        bus.G_flat   = g_v;
        pulse_start();
        chk("b2b_done_at_e0", 64'(bus.done), 64'd1);
        chk("b2b_busy_at_e0", 64'(bus.busy), 64'd1);
        bad = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 1) chk("b2b_done_falls", 64'(bus.done), 64'd0);
            if (bus.perm_flat !== old_perm || bus.hard_flat !== old_hard ||
                bus.Gpp_flat !== old_gpp || bus.done !== 1'b0) bad++;
        end
        chk("b2b_hold", 64'(bad), 64'd0);
        @(posedge clk); #1;
        chk("b2b_done_e10", 64'(bus.done), 64'd1);
        check_outputs("b2b", llr_v, g_v);

        // Randomized runs, alternating wide range and tie-heavy narrow range
        for (int t = 0; t < 24; t++) begin
            for (int j = 0; j < N; j++) begin
                if (t % 2 == 1) v = int'($urandom_range(0, 4)) - 2;
                else            v = int'($urandom_range(0, 63)) - 32;
                llr_v[j*W +: W] = v[W-1:0];
            end
            g_v = $urandom;
            run_check($sformatf("rnd%0d", t), llr_v, g_v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
